// File: rtl/titan_pkg.sv
// Shared defaults and state encoding for the operand-fetch stage.
package titan_pkg;
    localparam int REGBITS_DEF = 5;
    localparam int WIDTH_DEF   = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HAZ,
        ST_READ,
        ST_VALID
    } of_state_e;
endpackage

// File: rtl/op_scoreboard.sv
// Pending-write scoreboard: one bit per register plus one for the return-address
// register, with a combinational hazard check over two sources and RA.
module op_scoreboard #(
    parameter int REGBITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               set_en_i,
    input  logic [REGBITS-1:0] set_addr_i,
    input  logic               set_ra_i,
    input  logic               clr_en_i,
    input  logic [REGBITS-1:0] clr_addr_i,
    input  logic               clr_ra_i,
    input  logic [REGBITS-1:0] src_a_i,
    input  logic [REGBITS-1:0] src_b_i,
    input  logic               use_ra_i,
    output logic               hazard_o
);
    localparam int NREG = 1 << REGBITS;

    logic [NREG-1:0] pend_q, pend_d;
    logic            pend_ra_q, pend_ra_d;

    // Clear applied before set so a same-cycle set on the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
        if (set_en_i) pend_d[set_addr_i] = 1'b1;
        pend_d[0] = 1'b0;
        pend_ra_d = (pend_ra_q & ~clr_ra_i) | set_ra_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q    <= '0;
            pend_ra_q <= 1'b0;
        end else begin
            pend_q    <= pend_d;
            pend_ra_q <= pend_ra_d;
        end
    end

    assign hazard_o = pend_q[src_a_i] | pend_q[src_b_i] | (use_ra_i & pend_ra_q);
endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: holds one decoded instruction, waits out RAW hazards,
// reads the register file (with writeback bypass) and hands operands to execute.
module operand_fetch
    import titan_pkg::*;
#(
    parameter int REGBITS = REGBITS_DEF,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [REGBITS-1:0] in_rs,
    input  logic [REGBITS-1:0] in_rt,
    input  logic [REGBITS-1:0] in_rdest,
    input  logic               in_wr,
    input  logic               in_use_ra,
    input  logic               in_ra_wr,
    output logic [REGBITS-1:0] rf_rs,
    output logic [REGBITS-1:0] rf_rt,
    input  logic [WIDTH-1:0]   rf_rs_data,
    input  logic [WIDTH-1:0]   rf_rt_data,
    input  logic [WIDTH-1:0]   rf_ra_data,
    input  logic               wb_en,
    input  logic [REGBITS-1:0] wb_addr,
    input  logic [WIDTH-1:0]   wb_data,
    input  logic               wb_ra_en,
    input  logic [WIDTH-1:0]   wb_ra_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [WIDTH-1:0]   out_ra,
    output logic [REGBITS-1:0] out_rdest,
    output logic               out_wr,
    output logic               out_ra_wr
);
    of_state_e          state_q, state_d;
    logic [REGBITS-1:0] rs_q, rt_q, rdest_q;
    logic               wr_q, use_ra_q, ra_wr_q;
    logic [WIDTH-1:0]   a_q, b_q, ra_q, a_d, b_d, ra_d;
    logic               wb_en_q, wb_ra_en_q;
    logic [REGBITS-1:0] wb_addr_q;
    logic [WIDTH-1:0]   wb_data_q, wb_ra_data_q;
    logic               hazard, fire;

    op_scoreboard #(.REGBITS(REGBITS)) u_sb (
        .clk        (clk),
        .reset      (reset),
        .set_en_i   (fire & wr_q & (rdest_q != '0)),
        .set_addr_i (rdest_q),
        .set_ra_i   (fire & ra_wr_q),
        .clr_en_i   (wb_en),
        .clr_addr_i (wb_addr),
        .clr_ra_i   (wb_ra_en),
        .src_a_i    (rs_q),
        .src_b_i    (rt_q),
        .use_ra_i   (use_ra_q),
        .hazard_o   (hazard)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        fire      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = ~reset;
                if (in_valid) state_d = ST_HAZ;
            end
            ST_HAZ:   if (!hazard) state_d = ST_READ;
            ST_READ:  state_d = ST_VALID;
            ST_VALID: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    fire    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // The register file reads before it writes, so a writeback on the sampling
    // edge is only visible through the registered copy below.
    always_comb begin
        a_d  = rf_rs_data;
        b_d  = rf_rt_data;
        ra_d = rf_ra_data;
        if (wb_en_q && wb_addr_q == rs_q) a_d = wb_data_q;
        if (wb_en_q && wb_addr_q == rt_q) b_d = wb_data_q;
        if (wb_ra_en_q) ra_d = wb_ra_data_q;
        if (rs_q == '0) a_d = '0;
        if (rt_q == '0) b_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            rs_q         <= '0;
            rt_q         <= '0;
            rdest_q      <= '0;
            wr_q         <= 1'b0;
            use_ra_q     <= 1'b0;
            ra_wr_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            ra_q         <= '0;
            wb_en_q      <= 1'b0;
            wb_addr_q    <= '0;
            wb_data_q    <= '0;
            wb_ra_en_q   <= 1'b0;
            wb_ra_data_q <= '0;
        end else begin
            state_q      <= state_d;
            wb_en_q      <= wb_en;
            wb_addr_q    <= wb_addr;
            wb_data_q    <= wb_data;
            wb_ra_en_q   <= wb_ra_en;
            wb_ra_data_q <= wb_ra_data;
            if (state_q == ST_IDLE && in_valid) begin
                rs_q     <= in_rs;
                rt_q     <= in_rt;
                rdest_q  <= in_rdest;
                wr_q     <= in_wr;
                use_ra_q <= in_use_ra;
                ra_wr_q  <= in_ra_wr;
            end
            if (state_q == ST_READ) begin
                a_q  <= a_d;
                b_q  <= b_d;
                ra_q <= ra_d;
            end
        end
    end

    assign rf_rs     = (state_q == ST_IDLE) ? in_rs : rs_q;
    assign rf_rt     = (state_q == ST_IDLE) ? in_rt : rt_q;
    assign out_a     = a_q;
    assign out_b     = b_q;
    assign out_ra    = ra_q;
    assign out_rdest = rdest_q;
    assign out_wr    = wr_q;
    assign out_ra_wr = ra_wr_q;
endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register-file model, architectural shadow state and
// a pending-write model derived from the stage's hazard and sampling rules.
module tb_operand_fetch;
    logic        clk, reset;
    logic        in_valid, in_ready;
    logic [4:0]  in_rs, in_rt, in_rdest;
    logic        in_wr, in_use_ra, in_ra_wr;
    logic [4:0]  rf_rs, rf_rt;
    logic [31:0] rf_rs_data, rf_rt_data, rf_ra_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_ra_en;
    logic [31:0] wb_ra_data;
    logic        out_valid, out_ready;
    logic [31:0] out_a, out_b, out_ra;
    logic [4:0]  out_rdest;
    logic        out_wr, out_ra_wr;

    operand_fetch #(.REGBITS(5), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rt(in_rt), .in_rdest(in_rdest),
        .in_wr(in_wr), .in_use_ra(in_use_ra), .in_ra_wr(in_ra_wr),
        .rf_rs(rf_rs), .rf_rt(rf_rt),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data), .rf_ra_data(rf_ra_data),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ra_en(wb_ra_en), .wb_ra_data(wb_ra_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_ra(out_ra),
        .out_rdest(out_rdest), .out_wr(out_wr), .out_ra_wr(out_ra_wr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: registered read data, read-before-write.
    logic [31:0] rf_mem [32];
    logic [31:0] ra_mem;
    always @(posedge clk) begin
        rf_rs_data <= rf_mem[rf_rs];
        rf_rt_data <= rf_mem[rf_rt];
        rf_ra_data <= ra_mem;
        if (wb_en)    rf_mem[wb_addr] <= wb_data;
        if (wb_ra_en) ra_mem <= wb_ra_data;
    end

    int total = 0;
    int bad   = 0;
    logic [31:0] shadow [32];
    logic [31:0] shadow_ra;
    logic [31:0] pend_m;
    logic        pend_ra_m;
    logic        rand_wb;
    logic [4:0]  cur_rdest;
    logic        cur_wr, cur_ra_wr;
    logic [31:0] exp_a, exp_b, exp_ra;

    typedef struct packed {
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        sw_en;
        logic [4:0]  sw_addr;
        logic [31:0] sw_data;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: fold this edge's writebacks and handshake into the model,
    // advance to the next negedge, then pick the next cycle's writeback.
    task automatic cycle();
        logic fire;
        fire = out_valid && out_ready;
        if (wb_en) begin
            shadow[wb_addr] = wb_data;
            pend_m[wb_addr] = 1'b0;
        end
        if (wb_ra_en) begin
            shadow_ra = wb_ra_data;
            pend_ra_m = 1'b0;
        end
        if (fire) begin
            if (cur_wr && cur_rdest != 0) pend_m[cur_rdest] = 1'b1;
            if (cur_ra_wr) pend_ra_m = 1'b1;
        end
        if (reset) begin
            pend_m    = '0;
            pend_ra_m = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        if (rand_wb) begin
            wb_en = ($urandom_range(0, 2) == 0);
            if (pend_m != 0 && $urandom_range(0, 1) == 1) begin
                do wb_addr = 5'($urandom_range(1, 31)); while (!pend_m[wb_addr]);
            end else begin
                wb_addr = 5'($urandom_range(0, 7));
            end
            wb_data    = $urandom;
            wb_ra_en   = ($urandom_range(0, 3) == 0);
            wb_ra_data = $urandom;
        end else begin
            wb_en    = 1'b0;
            wb_ra_en = 1'b0;
        end
    endtask

    task automatic present(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rdest,
                           input logic wr, input logic use_ra, input logic ra_wr);
        chk("accept_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rdest = rdest;
        in_wr = wr; in_use_ra = use_ra; in_ra_wr = ra_wr;
        cur_rdest = rdest; cur_wr = wr; cur_ra_wr = ra_wr;
        cycle();
        in_valid = 1'b0;
        in_rs = 5'($urandom); in_rt = 5'($urandom); in_rdest = 5'($urandom);
        in_wr = 1'($urandom); in_use_ra = 1'($urandom); in_ra_wr = 1'($urandom);
        chk("busy_ready", 32'(in_ready), 32'd0);
        chk("rf_rs_held", 32'(rf_rs), 32'(rs));
    endtask

    // Operands must reflect architectural state as of the first edge after
    // accept at which none of the sources is pending; valid follows one edge later.
    task automatic issue_to_valid(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rdest,
                                  input logic wr, input logic use_ra, input logic ra_wr,
                                  input logic sw_en, input logic [4:0] sw_addr,
                                  input logic [31:0] sw_data, output int waits);
        logic haz;
        bit   done;
        present(rs, rt, rdest, wr, use_ra, ra_wr);
        waits = 0;
        done  = 0;
        while (!done && waits < 200) begin
            haz = pend_m[rs] | pend_m[rt] | (use_ra & pend_ra_m);
            if (!haz) begin
                done = 1;
                if (sw_en) begin
                    wb_en = 1'b1; wb_addr = sw_addr; wb_data = sw_data;
                end
            end
            cycle();
            waits++;
            chk("early_valid", 32'(out_valid), 32'd0);
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL haz_timeout: got stuck expected release within 200 cycles");
        end
        exp_a  = (rs == 0) ? 32'd0 : shadow[rs];
        exp_b  = (rt == 0) ? 32'd0 : shadow[rt];
        exp_ra = shadow_ra;
        cycle();
        chk("valid", 32'(out_valid), 32'd1);
        chk("out_a", out_a, exp_a);
        chk("out_b", out_b, exp_b);
        chk("out_ra", out_ra, exp_ra);
        chk("out_rdest", 32'(out_rdest), 32'(rdest));
        chk("out_wr", 32'(out_wr), 32'(wr));
        chk("out_ra_wr", 32'(out_ra_wr), 32'(ra_wr));
    endtask

    task automatic finish_instr(input int hold, input logic swe, input logic [4:0] swa,
                                input logic fwe, input logic [4:0] fwa);
        out_ready = 1'b0;
        for (int k = 0; k < hold; k++) begin
            if (k == 0 && swe) begin
                wb_en = 1'b1; wb_addr = swa; wb_data = $urandom;
            end
            cycle();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_a", out_a, exp_a);
            chk("hold_b", out_b, exp_b);
            chk("hold_ra", out_ra, exp_ra);
            chk("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        if (fwe) begin
            wb_en = 1'b1; wb_addr = fwa; wb_data = $urandom;
        end
        cycle();
        chk("post_fire_valid", 32'(out_valid), 32'd0);
        chk("post_fire_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int w;
        tbl[0] = '{5'd3, 5'd4, 1'b0, 5'd0, 32'h0,    32'h11, 32'h22};
        tbl[1] = '{5'd0, 5'd3, 1'b1, 5'd0, 32'h1234, 32'h0,  32'h11};
        tbl[2] = '{5'd3, 5'd7, 1'b1, 5'd7, 32'h77,   32'h11, 32'h77};
        tbl[3] = '{5'd7, 5'd0, 1'b0, 5'd0, 32'h0,    32'h77, 32'h0};
        tbl[4] = '{5'd4, 5'd4, 1'b1, 5'd4, 32'h44,   32'h44, 32'h44};

        reset = 1'b1; in_valid = 1'b0; in_rs = 0; in_rt = 0; in_rdest = 0;
        in_wr = 0; in_use_ra = 0; in_ra_wr = 0; out_ready = 1'b1;
        wb_en = 0; wb_addr = 0; wb_data = 0; wb_ra_en = 0; wb_ra_data = 0;
        rand_wb = 1'b0; pend_m = '0; pend_ra_m = 1'b0;
        cur_rdest = 0; cur_wr = 0; cur_ra_wr = 0;
        cycle();
        cycle();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        chk("rst_ra", out_ra, 32'd0);
        chk("rst_rdest", 32'(out_rdest), 32'd0);
        chk("rst_wr", 32'(out_wr), 32'd0);
        chk("rst_ra_wr", 32'(out_ra_wr), 32'd0);

        // Preload the register file (r0 deliberately non-zero in the array).
        for (int i = 0; i < 32; i++) begin
            wb_en = 1'b1; wb_addr = 5'(i);
            case (i)
                0:       wb_data = 32'hFFFF;
                3:       wb_data = 32'h11;
                4:       wb_data = 32'h22;
                7:       wb_data = 32'h01;
                default: wb_data = $urandom;
            endcase
            cycle();
        end
        wb_ra_en = 1'b1; wb_ra_data = 32'hAAAA;
        cycle();
        reset = 1'b0;
        cycle();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            issue_to_valid(tbl[i].rs, tbl[i].rt, 5'd0, 1'b0, 1'b0, 1'b0,
                           tbl[i].sw_en, tbl[i].sw_addr, tbl[i].sw_data, w);
            chk("tbl_latency", 32'(w), 32'd1);
            chk("tbl_a", out_a, tbl[i].exp_a);
            chk("tbl_b", out_b, tbl[i].exp_b);
            finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);
        end

        // RAW hazard on r5 released by writeback.
        issue_to_valid(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);
        present(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("haz_wait", 32'(out_valid), 32'd0);
        end
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'hABCD;
        cycle();
        chk("haz_e", 32'(out_valid), 32'd0);
        cycle();
        chk("haz_e1", 32'(out_valid), 32'd0);
        cycle();
        chk("haz_e2_valid", 32'(out_valid), 32'd1);
        chk("haz_a", out_a, 32'hABCD);
        exp_a = 32'hABCD; exp_b = 32'd0; exp_ra = shadow_ra;
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Writer to r0 never marks it pending.
        issue_to_valid(5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);
        issue_to_valid(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        chk("r0_no_pend", 32'(w), 32'd1);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Back-pressure: clear of r11 during stall, set/clear collision on r9.
        issue_to_valid(5'd3, 5'd4, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);
        issue_to_valid(5'd3, 5'd4, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        finish_instr(5, 1'b1, 5'd11, 1'b1, 5'd9);
        issue_to_valid(5'd11, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        chk("stall_clr_kept", 32'(w), 32'd1);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);
        present(5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle();
            chk("set_wins", 32'(out_valid), 32'd0);
        end
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'h99;
        cycle(); cycle(); cycle();
        chk("r9_valid", 32'(out_valid), 32'd1);
        chk("r9_b", out_b, 32'h99);
        exp_a = 32'd0; exp_b = 32'h99; exp_ra = shadow_ra;
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Reset while waiting in HAZ drops the instruction and pending bits.
        issue_to_valid(5'd3, 5'd4, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);
        present(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cycle();
        reset = 1'b1;
        cycle();
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_a", out_a, 32'd0);
        reset = 1'b0;
        cycle();
        chk("mid_rst_idle", 32'(in_ready), 32'd1);
        issue_to_valid(5'd5, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, w);
        chk("mid_rst_pend_clr", 32'(w), 32'd1);
        finish_instr(0, 1'b0, 5'd0, 1'b0, 5'd0);

        // Randomized traffic with background writebacks.
        rand_wb = 1'b1;
        for (int n = 0; n < 60; n++) begin
            issue_to_valid(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                           1'($urandom_range(0, 3) == 0), 1'b0, 5'd0, 32'd0, w);
            finish_instr($urandom_range(0, 2), 1'b0, 5'd0, 1'b0, 5'd0);
        end
        rand_wb = 1'b0;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
